// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the handshaked ALU.
//   - op codes OP_ADD..OP_XOR (3-bit)
//   - FSM state type state_t (ST_IDLE / ST_BUSY / ST_DONE)
//   - bit positions of the {V,C,N,Z} status flags
//   - pack_flags helper that builds the flag vector from its four bits
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle pulse; captures a and b and starts WIDTH steps
//   a, b     : multiplicand, multiplier
//   done     : one-cycle pulse when product holds the final value
//   product  : full 2*WIDTH-bit product (held until the next start)
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import alu_pkg::*;

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= '0;
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        cnt     <= CW'(WIDTH);
      end else if (cnt != '0) begin
        // One multiplier bit per cycle, LSB first; multiplicand moves up.
        if (mplier[0]) begin
          product <= product + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        done   <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/alu_hs.sv
// alu_hs: handshaked ALU with registered result and {V,C,N,Z} flags.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake; op, a, b captured on acceptance
//   op, a, b            : operation code and operands (b = shift amount)
//   out_valid/out_ready : response handshake
//   result, flags       : registered result and status flags {V,C,N,Z}
//   busy                : high while a multiply iterates
module alu_hs #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);
  import alu_pkg::*;

  localparam logic [SHW-1:0] WIDTH_AMT = SHW'(WIDTH);

  state_t state;

  logic accept;
  logic mul_start;
  logic mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic mul_hi;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SHW-1:0]   shamt;
  logic             shamt_over;

  assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_hi = |mul_product[2*WIDTH-1:WIDTH];

  // Amounts above WIDTH (including any set bit above the SHW field) zero
  // both result and carry, so only in-range amounts reach the shifters.
  assign shamt      = b[SHW-1:0];
  assign shamt_over = (|b[WIDTH-1:SHW]) | (shamt > WIDTH_AMT);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    add_ext = '0;
    sub_ext = '0;
    case (op)
      OP_ADD: begin
        add_ext = {1'b0, a} + {1'b0, b};
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sub_ext = {1'b0, a} - {1'b0, b};
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = ~sub_ext[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        // Extra bit above the operand catches the last bit shifted out.
        if (!shamt_over) begin
          {alu_c, alu_res} = {1'b0, a} << shamt;
        end
      end
      OP_SHR: begin
        // Extra bit below the operand catches the last bit shifted out.
        if (!shamt_over) begin
          {alu_res, alu_c} = {a, 1'b0} >> shamt;
        end
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state     <= ST_BUSY;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              state     <= ST_DONE;
              result    <= alu_res;
              flags     <= pack_flags(alu_v, alu_c, alu_res[WIDTH-1], alu_res == '0);
              out_valid <= 1'b1;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= mul_product[WIDTH-1:0];
            flags     <= pack_flags(mul_hi, mul_hi, mul_product[WIDTH-1],
                                    mul_product[WIDTH-1:0] == '0);
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
module tb_alu_hs;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        busy;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_hs #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: a response handshake is taken on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", 32'(result), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_result", 32'(result), 32'(e.r));
          chk("sb_flags", 32'(flags), 32'(e.f));
        end
      end
    end
  end

  // Issue one request; optionally push its expected response.
  task automatic send(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic push, input logic [15:0] er, input logic [3:0] ef);
    logic got;
    exp_t e;
    if (push) begin
      e.r = er;
      e.f = ef;
      sb.push_back(e);
    end
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // ADD overflow, latency 1
    send(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1010);
    @(negedge clk);
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    send(OP_SUB, 16'd5, 16'd5, 1'b1, 16'h0000, 4'b0101);
    send(OP_SUB, 16'd3, 16'd5, 1'b1, 16'hFFFE, 4'b0010);
    send(OP_SHL, 16'h8001, 16'd1, 1'b1, 16'h0002, 4'b0100);
    send(OP_SHR, 16'h0003, 16'd16, 1'b1, 16'h0000, 4'b0001);
    send(OP_SHL, 16'h1234, 16'd0, 1'b1, 16'h1234, 4'b0000);
    send(OP_SHR, 16'h8000, 16'd17, 1'b1, 16'h0000, 4'b0001);
    send(OP_SHR, 16'h8000, 16'd15, 1'b1, 16'h0001, 4'b0000);
    send(OP_XOR, 16'hA5A5, 16'hFFFF, 1'b1, 16'h5A5A, 4'b0000);
    send(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b0101);

    // MUL with overflow: busy window and WIDTH+1 latency
    send(OP_MUL, 16'h0100, 16'h0100, 1'b1, 16'h0000, 4'b1101);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_out_valid_low", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("mul_out_valid_17", 32'(out_valid), 32'd1);
    chk("mul_busy_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    send(OP_MUL, 16'd300, 16'd7, 1'b1, 16'h0834, 4'b0000);
    repeat (20) @(posedge clk);
    #1;

    // Backpressure, then back-to-back OR accepted on the release edge
    out_ready = 1'b0;
    send(OP_AND, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 4'b0010);
    begin
      exp_t e;
      e.r = 16'h0FF0;
      e.f = 4'b0000;
      sb.push_back(e);
    end
    op       = OP_OR;
    a        = 16'h0F00;
    b        = 16'h00F0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'hF000);
      chk("bp_flags", 32'(flags), 32'b0010);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", 32'(out_valid), 32'd1);
    chk("b2b_result", 32'(result), 32'h0FF0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply discards it
    send(OP_MUL, 16'd9, 16'd9, 1'b0, 16'h0, 4'h0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (25) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    send(OP_ADD, 16'd2, 16'd3, 1'b1, 16'h0005, 4'b0000);
    repeat (4) @(posedge clk);
    #1;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_hs.md
Name: alu_hs

Overview:
- Parametrised, handshaked successor to the datapath's combinational ALU.
- Registers every result and generates V/C/N/Z status flags.
- Adds an iterative shift-add multiply (MUL) and XOR.
- Sits between the decode/operand-fetch stage and writeback: the decode stage drives it through a valid/ready request, and writeback consumes it through a valid/ready response.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 4.
- SHW, $clog2(WIDTH)+1, width of the shift-amount field compared against WIDTH (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge
- op  in  3  operation code (see Behaviour)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount for SHL/SHR)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result when out_valid & out_ready at a clk edge
- result  out  WIDTH  registered result
- flags  out  4  {V,C,N,Z}, registered with result
- busy  out  1  high while a MUL iterates

Behaviour:
- op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR (logical), 110 MUL (low WIDTH bits of product), 111 XOR. All eight codes are legal.
- States: IDLE, BUSY, DONE.
- Reset (synchronous): state=IDLE; result=0; flags=0; out_valid=0; busy=0; the MUL counter and accumulators are cleared. A reset asserted during BUSY or DONE aborts the operation and discards any pending result.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready only, never from in_valid.
- Operands and op are captured only on acceptance. Changes while the request is not accepted have no effect.

State transitions:
- IDLE, accept, non-MUL: compute, load result/flags, go to DONE. out_valid is high in the cycle after the acceptance edge (latency 1).
- IDLE, accept, MUL: go to BUSY and load the counter with WIDTH.
- BUSY: one shift-add step per cycle. After WIDTH steps, load result/flags and go to DONE. out_valid rises WIDTH+1 cycles after the acceptance edge. busy=1 throughout BUSY. New requests are refused.
- DONE: hold result/flags/out_valid stable until out_ready.
  - out_ready & !in_valid: go to IDLE; out_valid drops next cycle.
  - out_ready & in_valid: back-to-back. The new request is accepted on the same edge and handled as from IDLE. For a non-MUL request, out_valid stays high with the new result.

Arithmetic (all computed at WIDTH bits, wrap-around modulo 2^WIDTH):
- Z = (result==0); N = result[WIDTH-1].
- ADD: C = carry out of bit WIDTH-1; V = signed overflow.
- SUB: result = a-b; C = 1 when a>=b unsigned (no borrow); V = signed overflow.
- AND, OR, XOR: C=0, V=0.
- SHL/SHR, amt = b as unsigned:
  - amt=0: result=a, C=0.
  - 1<=amt<=WIDTH: C = last bit shifted out.
  - amt>=WIDTH: result=0.
  - amt>WIDTH: C=0.
  - V=0 in all shift cases.
- MUL: unsigned. result = low WIDTH bits of the product. C = V = (upper WIDTH bits of the 2*WIDTH product != 0).

Decomposition:
- Package alu_pkg holds:
  - op localparams OP_ADD..OP_XOR;
  - the state encoding (IDLE/BUSY/DONE);
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
- One sub-module, alu_mul_iter: start/done pulse interface, WIDTH-cycle shift-add, exposes the 2*WIDTH product.
- The FSM, combinational single-cycle datapath and output register stay in alu_hs.

Test Plan (WIDTH=16):
- Reset, then ADD a=16'h7FFF, b=16'h0001 with out_ready=1 -> out_valid one cycle after acceptance; result=16'h8000, flags V=1,C=0,N=1,Z=0; reset values all zero.
- SUB a=5, b=5, then SUB a=3, b=5 -> first: result=0, Z=1, C=1; second: result=16'hFFFE, N=1, C=0, V=0.
- SHL a=16'h8001, b=1 -> result=16'h0002, C=1. SHR a=16'h0003, b=16 -> result=0, C=0, Z=1. SHL b=0 -> result=a, C=0.
- MUL a=16'h0100, b=16'h0100 -> busy=1 and in_ready=0 for 16 cycles; out_valid at cycle 17 after acceptance; result=0, C=V=1, Z=1. MUL 300*7 -> 2100 (16'h0834), C=0.
- Backpressure: hold out_ready=0 for 5 cycles after an AND result -> result/flags/out_valid stable, in_ready=0. Then out_ready=1 with a queued OR request -> accepted on the same edge; the next cycle shows the OR result with out_valid continuously high.
- Assert rst midway through a MUL (cycle 8) -> next cycle state IDLE, busy=0, out_valid=0, result=0. A following ADD 2+3 returns 5 normally.
